mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single external memory port (mem_addr/mem_read/mem_write/mem_wdata/mem_rdata/mem_ready) between
//  the pipeline's IF-stage instruction fetch (I side) and MEM-stage load/store (D side). Sits between the
//  pipelined core and memory. Grants one access at a time, holds memory signals stable until mem_ready,
//  returns read data with a one-cycle ready pulse and exposes per-side stall for the hazard logic.
// PARAMETERS
//  FAIR     1   1: alternate I/D grants when both pending in IDLE; 0: D always wins
//  TIMEOUT  255 max cycles waiting on mem_ready before abort (used only with MEM_ARB_TIMEOUT_EN); 8-bit counter
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  i_req      in   1   fetch request, level, held until i_ready
//  i_addr     in   32  fetch address, stable while i_req
//  i_rdata    out  32  fetched instruction, valid when i_ready
//  i_ready    out  1   one-cycle completion pulse, I side
//  i_stall    out  1   i_req high and no i_ready this cycle
//  d_read     in   1   load request, level, held until d_ready
//  d_write    in   1   store request, level, held until d_ready
//  d_addr     in   32  data address, stable while request
//  d_wdata    in   32  store data, stable while d_write
//  d_rdata    out  32  load data, valid when d_ready
//  d_ready    out  1   one-cycle completion pulse, D side
//  d_stall    out  1   (d_read|d_write) high and no d_ready this cycle
//  mem_read   out  1   to memory, registered
//  mem_write  out  1   to memory, registered
//  mem_addr   out  32  to memory, registered
//  mem_wdata  out  32  to memory, registered
//  mem_rdata  in   32  from memory, sampled when mem_ready
//  mem_ready  in   1   memory completion, one cycle
//  arb_err    out  1   sticky timeout flag (constant 0 without MEM_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset (rst=0, any time incl. mid-access): state IDLE, all outputs 0, last_grant=I, in-flight access dropped.
//  - FSM: IDLE, IACC, DACC, RESP.
//  - IDLE: D pending if d_read|d_write. Only D -> DACC; only I -> IACC; both -> FAIR=0: DACC,
//    FAIR=1: side opposite last_grant. On grant, latch addr/wdata/op into mem_* regs (visible next cycle).
//  - d_read&d_write together: treated as write.
//  - IACC/DACC: mem_read (or mem_write) high and mem_* constant every cycle until mem_ready sampled high,
//    incl. mem_ready in the first ACC cycle. At that edge: mem_read/mem_write<=0, mem_rdata captured into
//    i_rdata/d_rdata (stores leave d_rdata unchanged), go RESP, last_grant updated.
//  - RESP: exactly one cycle; granted side's ready=1; no new grant; then IDLE. Requester drops or changes
//    its request in the ready cycle.
//  - Latency: request seen in IDLE at cycle 0 -> mem_read at 1 -> mem_ready at N>=1 -> ready at N+1.
//    Back-to-back accesses cost 2 idle bus cycles (RESP+IDLE).
//  - mem_ready in IDLE/RESP ignored. i_rdata/d_rdata hold value until next capture on same side.
//  - Request dropped mid-ACC (protocol violation): access still completes, ready still pulses.
//  - Stall outputs are combinational from request inputs and registered ready.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined: 8-bit wait counter cleared on grant, +1 per ACC cycle without mem_ready. When it
//    reaches TIMEOUT: drop mem_read/mem_write, load 32'hDEAD_BEEF into the side's rdata, go RESP (ready pulses),
//    set arb_err=1 until reset.
//  Not defined: no counter, ACC waits indefinitely, arb_err tied 0.
// TESTING
//  1 i_req only, addr 0x40, mem_ready 3 cycles after mem_read, rdata 0x2002_0005 -> mem_addr=0x40;
//    i_ready one cycle at N+1 with i_rdata=0x2002_0005; d_ready never.
//  2 d_write addr 0x100 wdata 0xA5A5_A5A5, mem_ready in first ACC cycle -> mem_write exactly 1 cycle;
//    d_ready 2 cycles after grant; d_rdata unchanged.
//  3 i_req and d_read both held, FAIR=1, last_grant=I after reset -> D granted first, then I;
//    FAIR=0 with D re-requested each RESP -> D every time.
//  4 mem_ready pulses while IDLE and RESP -> no state change, no ready pulse, no capture.
//  5 rst low during DACC with mem_read=1 -> all outputs 0 immediately; after release, fresh i_req served normally.
//  6 MEM_ARB_TIMEOUT_EN, TIMEOUT=10, mem_ready never -> mem_read drops after 10 ACC cycles, d_ready with
//    d_rdata=0xDEAD_BEEF, arb_err=1 sticky; without macro mem_read stays high 1000 cycles, arb_err=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch (I) and load/store (D).
// Optional: define MEM_ARB_TIMEOUT_EN to abort accesses stuck longer than TIMEOUT cycles.
module mem_port_arbiter #(
  parameter bit FAIR    = 1'b1,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  output logic        i_stall,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_stall,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        arb_err
);

  typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} state_t;

  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  state_t state_reg;
  state_t state_next;
  logic   last_grant_reg;  // 0: I side granted last, 1: D side
  logic   d_pend;
  logic   acc;
  logic   grant_i;
  logic   grant_d;
  logic   done;
  logic   abort;

  assign d_pend = d_read | d_write;
  assign acc    = (state_reg == IACC) || (state_reg == DACC);
  assign done   = acc && (mem_ready || abort);

  // Grant decision, only evaluated in IDLE
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_reg == IDLE) begin
      if (d_pend && i_req) begin
        grant_d = FAIR ? ~last_grant_reg : 1'b1;
        grant_i = ~grant_d;
      end else begin
        grant_d = d_pend;
        grant_i = i_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          state_next = DACC;
        end else if (grant_i) begin
          state_next = IACC;
        end
      end
      IACC, DACC: begin
        if (done) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stalls are held low during reset so every output reads 0 while rst is asserted
  always_comb begin
    i_stall = rst & i_req & ~i_ready;
    d_stall = rst & d_pend & ~d_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      i_rdata        <= '0;
      d_rdata        <= '0;
      i_ready        <= 1'b0;
      d_ready        <= 1'b0;
      last_grant_reg <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      if (grant_i) begin
        mem_read  <= 1'b1;
        mem_write <= 1'b0;
        mem_addr  <= i_addr;
      end else if (grant_d) begin
        // read+write together is a store
        mem_read  <= ~d_write;
        mem_write <= d_write;
        mem_addr  <= d_addr;
        if (d_write) begin
          mem_wdata <= d_wdata;
        end
      end else if (done) begin
        mem_read       <= 1'b0;
        mem_write      <= 1'b0;
        last_grant_reg <= (state_reg == DACC);
        if (state_reg == IACC) begin
          i_ready <= 1'b1;
          i_rdata <= abort ? ABORT_DATA : mem_rdata;
        end else begin
          d_ready <= 1'b1;
          if (abort) begin
            d_rdata <= ABORT_DATA;
          end else if (mem_read) begin
            d_rdata <= mem_rdata;
          end
        end
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt_reg;
  logic       arb_err_reg;

  // Abort on the cycle the counter would reach TIMEOUT
  assign abort   = acc && !mem_ready && (wait_cnt_reg == 8'(TIMEOUT - 1));
  assign arb_err = arb_err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_reg <= '0;
      arb_err_reg  <= 1'b0;
    end else begin
      if (grant_i || grant_d) begin
        wait_cnt_reg <= '0;
      end else if (acc && !mem_ready) begin
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      end
      if (abort) begin
        arb_err_reg <= 1'b1;
      end
    end
  end
`else
  logic [7:0] unused_timeout;

  assign abort          = 1'b0;
  assign arb_err        = 1'b0;
  assign unused_timeout = 8'(TIMEOUT);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked by a scoreboard monitor against a request-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam bit FAIR = 1'b1;
  localparam int TIMEOUT = 10;
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        i_stall;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_stall;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        arb_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.FAIR(FAIR), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_stall(i_stall),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .arb_err(arb_err)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] mem_store[logic [31:0]];
  logic [31:0] exp_d_last;
  bit drivers_done;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : hash(a);
  endfunction

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    return mem_store.exists(a) ? mem_store[a] : hash(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_ready(input bit side_d, input string name);
    int budget = 0;
    do begin
      step();
      budget++;
    end while (!(side_d ? d_ready : i_ready) && budget < 200);
    if (!(side_d ? d_ready : i_ready)) begin
      checks++;
      errors++;
      $display("FAIL %s: actual=no ready within %0d cycles required=ready pulse", name, budget);
    end
  endtask

  task automatic i_driver(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) step();
      i_addr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      i_req = 1'b1;
      exp_i_q.push_back(ref_get(i_addr));
      wait_ready(1'b0, "rand_i_wait");
      i_req = 1'b0;
    end
  endtask

  task automatic d_driver(input int n);
    for (int k = 0; k < n; k++) begin
      int op;
      repeat ($urandom_range(0, 3)) step();
      op = int'($urandom_range(0, 3));
      d_addr = 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4;
      d_wdata = $urandom;
      d_read = (op != 2);
      d_write = (op >= 2);
      if (d_write) begin
        ref_mem[d_addr] = d_wdata;
      end else begin
        exp_d_last = ref_get(d_addr);
      end
      exp_d_q.push_back(exp_d_last);
      wait_ready(1'b1, "rand_d_wait");
      d_read = 1'b0;
      d_write = 1'b0;
    end
  endtask

  // Memory with random latency; also throws stray mem_ready pulses while the bus is idle
  task automatic responder();
    int lat = -1;
    while (!drivers_done) begin
      step();
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (mem_read || mem_write) begin
        if (lat < 0) lat = int'($urandom_range(0, 3));
        if (lat == 0) begin
          mem_ready = 1'b1;
          if (mem_read) mem_rdata = mem_get(mem_addr);
          else mem_store[mem_addr] = mem_wdata;
          lat = -1;
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        mem_ready = 1'b1;
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic monitor();
    logic p_op = 1'b0, p_ireq = 1'b0, p_dpend = 1'b0, p_dwr = 1'b0, p_done = 1'b0;
    logic [31:0] p_iaddr = '0, p_daddr = '0, p_dwdata = '0, p_maddr = '0, p_mwdata = '0;
    logic last_side = SIDE_I;
    logic cur_side = SIDE_I;
    logic op;
    while (!drivers_done) begin
      @(negedge clk);
      op = mem_read | mem_write;
      check_bit("i_stall", i_stall, i_req & ~i_ready);
      check_bit("d_stall", d_stall, (d_read | d_write) & ~d_ready);
      check_bit("i_ready_timing", i_ready, p_done && cur_side == SIDE_I);
      check_bit("d_ready_timing", d_ready, p_done && cur_side == SIDE_D);
      if (i_ready) begin
        last_side = SIDE_I;
        if (exp_i_q.size() == 0) check("i_unexpected_ready", 32'd1, 32'd0);
        else check("i_rdata", i_rdata, exp_i_q.pop_front());
      end
      if (d_ready) begin
        last_side = SIDE_D;
        if (exp_d_q.size() == 0) check("d_unexpected_ready", 32'd1, 32'd0);
        else check("d_rdata", d_rdata, exp_d_q.pop_front());
      end
      if (op && !p_op) begin
        if (p_ireq && p_dpend) cur_side = FAIR ? ~last_side : SIDE_D;
        else cur_side = p_dpend ? SIDE_D : SIDE_I;
        if (cur_side == SIDE_I) begin
          check("grant_i_addr", mem_addr, p_iaddr);
          check_bit("grant_i_read", mem_read, 1'b1);
        end else begin
          check("grant_d_addr", mem_addr, p_daddr);
          check_bit("grant_d_write", mem_write, p_dwr);
          check_bit("grant_d_read", mem_read, ~p_dwr);
          if (p_dwr) check("grant_d_wdata", mem_wdata, p_dwdata);
        end
      end else if (p_op && !p_done) begin
        check_bit("mem_op_held", op, 1'b1);
        check("mem_addr_stable", mem_addr, p_maddr);
        check("mem_wdata_stable", mem_wdata, p_mwdata);
      end
      p_done = op && mem_ready;
      p_op = op;
      p_ireq = i_req;
      p_dpend = d_read | d_write;
      p_dwr = d_write;
      p_iaddr = i_addr;
      p_daddr = d_addr;
      p_dwdata = d_wdata;
      p_maddr = mem_addr;
      p_mwdata = mem_wdata;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=simulation still running required=finish");
    $fatal(1);
  end

  initial begin
    int hi;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_mem_read", mem_read, 1'b0);
    check_bit("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check_bit("rst_i_ready", i_ready, 1'b0);
    check_bit("rst_d_ready", d_ready, 1'b0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check_bit("rst_arb_err", arb_err, 1'b0);
    rst = 1'b1;

    // I fetch, memory answers 3 cycles after mem_read rises
    step();
    i_addr = 32'h40; i_req = 1'b1;
    step();
    check_bit("t1_mem_read", mem_read, 1'b1);
    check("t1_mem_addr", mem_addr, 32'h40);
    repeat (2) begin
      step();
      check_bit("t1_mem_read_hold", mem_read, 1'b1);
    end
    step();
    check_bit("t1_no_early_ready", i_ready, 1'b0);
    mem_ready = 1'b1; mem_rdata = 32'h2002_0005;
    step();
    mem_ready = 1'b0;
    check_bit("t1_i_ready", i_ready, 1'b1);
    check("t1_i_rdata", i_rdata, 32'h2002_0005);
    check_bit("t1_d_ready", d_ready, 1'b0);
    check_bit("t1_mem_read_drop", mem_read, 1'b0);
    i_req = 1'b0;
    step();
    check_bit("t1_i_ready_pulse", i_ready, 1'b0);

    // Store answered in the first access cycle
    d_addr = 32'h100; d_wdata = 32'hA5A5_A5A5; d_write = 1'b1;
    step();
    check_bit("t2_mem_write", mem_write, 1'b1);
    check_bit("t2_mem_read", mem_read, 1'b0);
    check("t2_mem_addr", mem_addr, 32'h100);
    check("t2_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ready = 1'b0;
    check_bit("t2_mem_write_1cyc", mem_write, 1'b0);
    check_bit("t2_d_ready", d_ready, 1'b1);
    check("t2_d_rdata_kept", d_rdata, 32'h0);
    d_write = 1'b0;
    step();

    // Both pending after reset: D first, then I; stray mem_ready in RESP and IDLE
    do_reset();
    i_addr = 32'h80; i_req = 1'b1;
    d_addr = 32'h200; d_read = 1'b1;
    step();
    check("t3_first_grant_d", mem_addr, 32'h200);
    check_bit("t3_first_read", mem_read, 1'b1);
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    check_bit("t3_d_ready", d_ready, 1'b1);
    check_bit("t3_i_ready_resp", i_ready, 1'b0);
    check("t3_d_rdata", d_rdata, 32'h1111_2222);
    d_read = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    step();
    check_bit("t4_idle_no_read", mem_read, 1'b0);
    check_bit("t4_no_d_ready", d_ready, 1'b0);
    check_bit("t4_no_i_ready", i_ready, 1'b0);
    check("t4_d_rdata_kept", d_rdata, 32'h1111_2222);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("t3_second_grant_i", mem_addr, 32'h80);
    check_bit("t3_second_read", mem_read, 1'b1);
    step();
    check_bit("t4_still_waiting", mem_read, 1'b1);
    check_bit("t4_no_capture_ready", i_ready, 1'b0);
    check("t4_i_rdata_kept", i_rdata, 32'h0);
    mem_ready = 1'b1; mem_rdata = 32'h3333_4444;
    step();
    mem_ready = 1'b0;
    check_bit("t3_i_ready", i_ready, 1'b1);
    check("t3_i_rdata", i_rdata, 32'h3333_4444);
    i_req = 1'b0;
    step();

    // Reset asserted in the middle of a load
    d_addr = 32'h300; d_read = 1'b1;
    step();
    check_bit("t5_mem_read_before", mem_read, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_bit("t5_mem_read_rst", mem_read, 1'b0);
    check("t5_mem_addr_rst", mem_addr, 32'h0);
    check("t5_d_rdata_rst", d_rdata, 32'h0);
    check_bit("t5_d_stall_rst", d_stall, 1'b0);
    d_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    i_addr = 32'h44; i_req = 1'b1;
    step();
    check_bit("t5_fresh_read", mem_read, 1'b1);
    check("t5_fresh_addr", mem_addr, 32'h44);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0044;
    step();
    mem_ready = 1'b0;
    check_bit("t5_fresh_ready", i_ready, 1'b1);
    check("t5_fresh_rdata", i_rdata, 32'hCAFE_0044);
    i_req = 1'b0;
    step();

    // Randomized traffic against the scoreboard
    do_reset();
    ref_mem.delete();
    mem_store.delete();
    exp_d_last = '0;
    drivers_done = 1'b0;
    fork
      begin
        fork
          i_driver(60);
          d_driver(60);
        join
        repeat (3) step();
        drivers_done = 1'b1;
      end
      responder();
      monitor();
    join
    check("rand_i_queue_empty", 32'(exp_i_q.size()), 32'd0);
    check("rand_d_queue_empty", 32'(exp_d_q.size()), 32'd0);

    // Memory that never answers
    do_reset();
    hi = 0;
`ifdef MEM_ARB_TIMEOUT_EN
    d_addr = 32'h500; d_read = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (d_ready) break;
      if (mem_read) hi++;
    end
    check("t6_read_cycles", 32'(hi), 32'(TIMEOUT));
    check_bit("t6_d_ready", d_ready, 1'b1);
    check("t6_d_rdata", d_rdata, 32'hDEAD_BEEF);
    check_bit("t6_arb_err", arb_err, 1'b1);
    d_read = 1'b0;
    repeat (3) step();
    check_bit("t6_arb_err_sticky", arb_err, 1'b1);
    check_bit("t6_bus_idle", mem_read, 1'b0);
`else
    i_addr = 32'h60; i_req = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (mem_read) hi++;
    end
    check("t6_read_cycles", 32'(hi), 32'd1000);
    check_bit("t6_arb_err", arb_err, 1'b0);
    check_bit("t6_no_ready", i_ready, 1'b0);
    mem_ready = 1'b1; mem_rdata = 32'h0600_0060;
    step();
    mem_ready = 1'b0;
    check_bit("t6_late_ready", i_ready, 1'b1);
    check("t6_late_rdata", i_rdata, 32'h0600_0060);
    i_req = 1'b0;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
